// File: rtl/apb_pwm_pkg.sv
// Register map constants and address decode helpers for the APB PWM array.
package apb_pwm_pkg;

  localparam logic [7:0]  OFF_CTRL   = 8'h00;
  localparam logic [7:0]  OFF_STATUS = 8'h04;
  localparam logic [7:0]  OFF_INTEN  = 8'h08;
  localparam logic [7:0]  CH_BASE    = 8'h10;
  localparam int unsigned CH_STRIDE  = 8;

  typedef enum logic [2:0] {
    REG_NONE,
    REG_CTRL,
    REG_STATUS,
    REG_INTEN,
    REG_PERIOD,
    REG_DUTY
  } reg_kind_e;

  function automatic logic [4:0] ch_index(input logic [7:0] off);
    return 5'((off - CH_BASE) / 8'(CH_STRIDE));
  endfunction

  // Misaligned offsets and channels beyond num_ch decode as REG_NONE.
  function automatic reg_kind_e decode_reg(input logic [7:0] off, input int unsigned num_ch);
    reg_kind_e kind;
    kind = REG_NONE;
    if (off[1:0] == 2'b00) begin
      if (off == OFF_CTRL)
        kind = REG_CTRL;
      else if (off == OFF_STATUS)
        kind = REG_STATUS;
      else if (off == OFF_INTEN)
        kind = REG_INTEN;
      else if ((off >= CH_BASE) && (32'(ch_index(off)) < num_ch))
        kind = off[2] ? REG_DUTY : REG_PERIOD;
    end
    return kind;
  endfunction

endpackage

// File: rtl/apb_pwm_array_channel.sv
// One PWM channel: counter, active (shadowed) period/duty and registered output.
module pwm_channel #(
  parameter int unsigned CNT_W      = 24,
  parameter int unsigned RST_PERIOD = 0,
  parameter int unsigned RST_DUTY   = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [CNT_W-1:0] pend_period,
  input  logic [CNT_W-1:0] pend_duty,
  output logic             pwm,
  output logic             wrap
);

  logic [CNT_W-1:0] count;
  logic [CNT_W-1:0] act_period;
  logic [CNT_W-1:0] act_duty;

  assign wrap = en && (count == act_period);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count      <= '0;
      act_period <= CNT_W'(RST_PERIOD);
      act_duty   <= CNT_W'(RST_DUTY);
      pwm        <= 1'b0;
    end else if (!en) begin
      count      <= '0;
      act_period <= pend_period;
      act_duty   <= pend_duty;
      pwm        <= 1'b0;
    end else begin
      pwm <= (count < act_duty);
      if (wrap) begin
        count      <= '0;
        act_period <= pend_period;
        act_duty   <= pend_duty;
      end else begin
        count <= count + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/apb_pwm_array.sv
// APB3 slave with NUM_CH shadowed PWM channels, sticky period-complete flags and IRQ.
module apb_pwm_array
  import apb_pwm_pkg::*;
#(
  parameter int unsigned NUM_CH     = 4,
  parameter int unsigned CNT_W      = 24,
  parameter int unsigned RST_PERIOD = 0,
  parameter int unsigned RST_DUTY   = 0
) (
  input  logic              PCLK,
  input  logic              PRESERN,
  input  logic              PSEL,
  input  logic              PENABLE,
  input  logic              PWRITE,
  input  logic [31:0]       PADDR,
  input  logic [31:0]       PWDATA,
  output logic [31:0]       PRDATA,
  output logic              PREADY,
  output logic              PSLVERR,
  output logic [NUM_CH-1:0] pwm_out,
  output logic              IRQ
);

  logic [7:0]       off;
  reg_kind_e        kind;
  logic [4:0]       idx;
  logic             wr;
  logic [NUM_CH-1:0] ctrl, status, inten, wrap_vec, w1c;
  logic [CNT_W-1:0] pend_period [NUM_CH];
  logic [CNT_W-1:0] pend_duty   [NUM_CH];
  logic [31:0]      rdata;
  logic             unused_bits;

  assign off         = PADDR[7:0];
  assign kind        = decode_reg(off, NUM_CH);
  assign idx         = ch_index(off);
  assign wr          = PSEL & PENABLE & PWRITE & (kind != REG_NONE);
  assign PSLVERR     = PSEL & PENABLE & (kind == REG_NONE);
  assign PREADY      = 1'b1;
  assign unused_bits = ^{PADDR[31:8], PWDATA};
  assign w1c         = (wr && (kind == REG_STATUS)) ? PWDATA[NUM_CH-1:0] : '0;

  always_ff @(posedge PCLK or negedge PRESERN) begin
    if (!PRESERN) begin
      ctrl   <= '0;
      inten  <= '0;
      status <= '0;
      IRQ    <= 1'b0;
    end else begin
      if (wr && (kind == REG_CTRL))  ctrl  <= PWDATA[NUM_CH-1:0];
      if (wr && (kind == REG_INTEN)) inten <= PWDATA[NUM_CH-1:0];
      // OR-ing wraps after the clear makes a same-cycle set win over W1C.
      status <= (status & ~w1c) | wrap_vec;
      IRQ    <= |(status & inten);
    end
  end

  always_ff @(posedge PCLK or negedge PRESERN) begin
    if (!PRESERN) begin
      for (int unsigned i = 0; i < NUM_CH; i++) begin
        pend_period[i] <= CNT_W'(RST_PERIOD);
        pend_duty[i]   <= CNT_W'(RST_DUTY);
      end
    end else begin
      for (int unsigned i = 0; i < NUM_CH; i++) begin
        if (wr && (32'(idx) == i)) begin
          if (kind == REG_PERIOD) pend_period[i] <= PWDATA[CNT_W-1:0];
          if (kind == REG_DUTY)   pend_duty[i]   <= PWDATA[CNT_W-1:0];
        end
      end
    end
  end

  always_comb begin
    rdata = '0;
    if (PSEL && !PWRITE && PRESERN) begin
      case (kind)
        REG_CTRL:   rdata = 32'(ctrl);
        REG_STATUS: rdata = 32'(status);
        REG_INTEN:  rdata = 32'(inten);
        REG_PERIOD, REG_DUTY: begin
          for (int unsigned i = 0; i < NUM_CH; i++) begin
            if (32'(idx) == i)
              rdata = (kind == REG_PERIOD) ? 32'(pend_period[i]) : 32'(pend_duty[i]);
          end
        end
        default: rdata = '0;
      endcase
    end
  end

  assign PRDATA = rdata;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    pwm_channel #(
      .CNT_W      (CNT_W),
      .RST_PERIOD (RST_PERIOD),
      .RST_DUTY   (RST_DUTY)
    ) u_ch (
      .clk         (PCLK),
      .rst_n       (PRESERN),
      .en          (ctrl[g]),
      .pend_period (pend_period[g]),
      .pend_duty   (pend_duty[g]),
      .pwm         (pwm_out[g]),
      .wrap        (wrap_vec[g])
    );
  end

endmodule

// File: tb/tb_apb_pwm_array.sv
// Directed self-checking bench for apb_pwm_array (4 channels, 24-bit counters).
module tb_apb_pwm_array;

  logic        PCLK = 1'b0;
  logic        PRESERN, PSEL, PENABLE, PWRITE;
  logic [31:0] PADDR, PWDATA, PRDATA;
  logic        PREADY, PSLVERR, IRQ;
  logic [3:0]  pwm_out;

  int checks = 0;
  int errors = 0;

  logic [31:0] rd;
  logic        er;

  always #5 PCLK = ~PCLK;

  apb_pwm_array #(
    .NUM_CH     (4),
    .CNT_W      (24),
    .RST_PERIOD (0),
    .RST_DUTY   (0)
  ) dut (
    .PCLK    (PCLK),
    .PRESERN (PRESERN),
    .PSEL    (PSEL),
    .PENABLE (PENABLE),
    .PWRITE  (PWRITE),
    .PADDR   (PADDR),
    .PWDATA  (PWDATA),
    .PRDATA  (PRDATA),
    .PREADY  (PREADY),
    .PSLVERR (PSLVERR),
    .pwm_out (pwm_out),
    .IRQ     (IRQ)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Register update lands on the posedge ending the access phase.
  task automatic apb_write(input logic [31:0] a, input logic [31:0] d);
    @(negedge PCLK);
    PSEL = 1'b1; PWRITE = 1'b1; PENABLE = 1'b0; PADDR = a; PWDATA = d;
    @(negedge PCLK);
    PENABLE = 1'b1;
    @(posedge PCLK);
    #1;
    PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
  endtask

  task automatic apb_read(input logic [31:0] a, output logic [31:0] d, output logic e);
    @(negedge PCLK);
    PSEL = 1'b1; PWRITE = 1'b0; PENABLE = 1'b0; PADDR = a;
    @(negedge PCLK);
    PENABLE = 1'b1;
    #1;
    d = PRDATA;
    e = PSLVERR;
    @(posedge PCLK);
    #1;
    PSEL = 1'b0; PENABLE = 1'b0;
  endtask

  // Expected pwm after the k-th edge following the enabling edge.
  function automatic logic exp_pwm(int k, int per, int d_old, int d_new, int ksw);
    int c;
    if (k == 0) return 1'b0;
    c = (k - 1) % (per + 1);
    return (c < ((k > ksw) ? d_new : d_old));
  endfunction

  initial begin
    PRESERN = 1'b0; PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
    PADDR = '0; PWDATA = '0;
    repeat (3) @(negedge PCLK);
    PRESERN = 1'b1;

    // Reset state
    check("rst pwm_out", 32'(pwm_out), 32'h0);
    check("rst IRQ", 32'(IRQ), 32'h0);
    check("PREADY", 32'(PREADY), 32'h1);
    apb_read(32'h00, rd, er); check("rst CTRL", rd, 32'h0); check("rst CTRL err", 32'(er), 32'h0);
    apb_read(32'h04, rd, er); check("rst STATUS", rd, 32'h0);
    apb_read(32'h08, rd, er); check("rst INTEN", rd, 32'h0);
    for (int n = 0; n < 4; n++) begin
      apb_read(32'(16 + 8 * n), rd, er); check($sformatf("rst PERIOD%0d", n), rd, 32'h0);
      check($sformatf("rst PERIOD%0d err", n), 32'(er), 32'h0);
      apb_read(32'(20 + 8 * n), rd, er); check($sformatf("rst DUTY%0d", n), rd, 32'h0);
    end
    apb_read(32'h7C, rd, er); check("unmapped 7C data", rd, 32'h0); check("unmapped 7C err", 32'(er), 32'h1);
    apb_read(32'h0C, rd, er); check("unmapped 0C err", 32'(er), 32'h1);
    apb_read(32'h30, rd, er); check("ch4 err", 32'(er), 32'h1);
    apb_read(32'h12, rd, er); check("misaligned err", 32'(er), 32'h1);
    apb_write(32'h12, 32'h55);
    apb_read(32'h10, rd, er); check("bad write ignored", rd, 32'h0);

    // Basic PWM: period 9, duty 3; upper PWDATA bits dropped
    apb_write(32'h10, 32'hFF00_0009);
    apb_read(32'h10, rd, er); check("PERIOD0 width", rd, 32'h9);
    apb_write(32'h14, 32'd3);
    apb_write(32'h00, 32'h1);
    for (int k = 0; k <= 20; k++) begin
      @(negedge PCLK);
      check($sformatf("basic k=%0d", k), 32'(pwm_out), 32'(exp_pwm(k, 9, 3, 3, 1000)));
    end

    // Shadow update mid-period: pending lands at k=23, takes effect after wrap at k=30
    apb_write(32'h14, 32'd7);
    for (int k = 23; k <= 52; k++) begin
      @(negedge PCLK);
      check($sformatf("shadow k=%0d", k), 32'(pwm_out), 32'(exp_pwm(k, 9, 3, 7, 30)));
    end
    apb_read(32'h14, rd, er); check("DUTY0 readback", rd, 32'd7);

    // Duty 0 -> constant low
    apb_write(32'h00, 32'h0);
    apb_write(32'h14, 32'd0);
    @(negedge PCLK);
    check("disable low", 32'(pwm_out), 32'h0);
    apb_write(32'h00, 32'h1);
    for (int k = 0; k < 12; k++) begin
      @(negedge PCLK);
      check($sformatf("duty0 k=%0d", k), 32'(pwm_out), 32'h0);
    end

    // Duty > period -> constant high
    apb_write(32'h00, 32'h0);
    apb_write(32'h14, 32'd20);
    apb_write(32'h00, 32'h1);
    for (int k = 0; k < 12; k++) begin
      @(negedge PCLK);
      check($sformatf("duty20 k=%0d", k), 32'(pwm_out), 32'(exp_pwm(k, 9, 20, 20, 1000)));
    end

    // Period 0, duty 1 -> constant high, flag every cycle, set beats W1C
    apb_write(32'h00, 32'h0);
    apb_write(32'h10, 32'd0);
    apb_write(32'h14, 32'd1);
    apb_write(32'h04, 32'h1);
    apb_read(32'h04, rd, er); check("STATUS cleared", rd, 32'h0);
    apb_write(32'h00, 32'h1);
    for (int k = 0; k < 6; k++) begin
      @(negedge PCLK);
      check($sformatf("per0 k=%0d", k), 32'(pwm_out), 32'(exp_pwm(k, 0, 1, 1, 1000)));
    end
    apb_read(32'h04, rd, er); check("per0 STATUS", rd, 32'h1);
    apb_write(32'h04, 32'h1);
    apb_read(32'h04, rd, er); check("set wins W1C", rd, 32'h1);

    // Interrupt: period 4, first wrap at k=5, IRQ from k=6
    apb_write(32'h00, 32'h0);
    apb_write(32'h10, 32'd4);
    apb_write(32'h14, 32'd2);
    apb_write(32'h04, 32'h1);
    apb_write(32'h08, 32'h1);
    apb_read(32'h08, rd, er); check("INTEN readback", rd, 32'h1);
    check("IRQ idle", 32'(IRQ), 32'h0);
    apb_write(32'h00, 32'h1);
    for (int k = 0; k <= 8; k++) begin
      @(negedge PCLK);
      check($sformatf("irq k=%0d", k), 32'(IRQ), 32'(k >= 6));
    end
    // W1C lands at k=11 (count 0, no wrap)
    apb_write(32'h04, 32'h1);
    @(negedge PCLK);
    check("IRQ before fall", 32'(IRQ), 32'h1);
    @(negedge PCLK);
    check("IRQ after W1C", 32'(IRQ), 32'h0);

    // Async reset with two channels running
    apb_write(32'h00, 32'h0);
    apb_write(32'h18, 32'd5);
    apb_write(32'h1C, 32'd3);
    apb_write(32'h00, 32'h3);
    for (int k = 0; k <= 7; k++) @(negedge PCLK);
    check("two ch running", 32'(pwm_out), 32'h3);
    check("IRQ running", 32'(IRQ), 32'h1);
    #2;
    PRESERN = 1'b0;
    #1;
    check("async rst pwm", 32'(pwm_out), 32'h0);
    check("async rst IRQ", 32'(IRQ), 32'h0);
    check("async rst PRDATA", PRDATA, 32'h0);
    @(negedge PCLK);
    PRESERN = 1'b1;
    apb_read(32'h00, rd, er); check("post rst CTRL", rd, 32'h0);
    apb_read(32'h04, rd, er); check("post rst STATUS", rd, 32'h0);
    apb_read(32'h18, rd, er); check("post rst PERIOD1", rd, 32'h0);
    apb_read(32'h1C, rd, er); check("post rst DUTY1", rd, 32'h0);
    for (int k = 0; k < 10; k++) begin
      @(negedge PCLK);
      check($sformatf("idle k=%0d", k), 32'(pwm_out), 32'h0);
    end
    check("idle IRQ", 32'(IRQ), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/apb_pwm_array.md
Name: apb_pwm_array

Overview:
- APB3 slave providing NUM_CH independent PWM channels.
- Each channel has a programmable period and duty, with shadow registers so updates are glitch-free.
- Provides per-channel enable and a sticky period-complete interrupt with mask and write-1-to-clear.
- Generalised successor to the fixed servo/motor/IR PWM generators in the fabric APB peripheral; one instance drives servos, motor PWM or IR carrier by configuration alone.

Parameters:
- NUM_CH, 4, number of PWM channels (1..8).
- CNT_W, 24, width of the period/duty/counter in PCLK cycles (8..32).
- RST_PERIOD, 0, reset value of every channel's period register.
- RST_DUTY, 0, reset value of every channel's duty register.

Ports:
- PCLK  in  1  clock.
- PRESERN  in  1  asynchronous active-low reset.
- PSEL  in  1  APB select.
- PENABLE  in  1  APB access phase.
- PWRITE  in  1  1=write, 0=read.
- PADDR  in  32  address; only PADDR[7:0] decoded.
- PWDATA  in  32  write data.
- PRDATA  out  32  read data.
- PREADY  out  1  tied 1 (zero wait states).
- PSLVERR  out  1  error on unmapped access.
- pwm_out  out  NUM_CH  channel outputs, bit n = channel n.
- IRQ  out  1  interrupt, level, active-high.

Behaviour:
- Register map (byte offsets on PADDR[7:0]):
  - 0x00 CTRL, RW, bit n = channel n enable.
  - 0x04 STATUS, R/W1C, bit n = channel n period-complete flag.
  - 0x08 INTEN, RW, bit n = interrupt mask.
  - 0x10+8n PERIOD[n], RW.
  - 0x14+8n DUTY[n], RW.
- Write strobe = PSEL & PENABLE & PWRITE. Registers update on the next PCLK edge.
- Read: PRDATA is combinational from PADDR when PSEL & ~PWRITE, so it is valid in the access phase. Unused upper bits read 0. PRDATA = 0 when not selected.
- PSLVERR = PSEL & PENABLE & (offset unmapped, or channel index ≥ NUM_CH, or offset not word-aligned). Erroneous writes have no effect; erroneous reads return 0.
- Shadow registers: PERIOD/DUTY writes go to pending registers (these are what reads return). Active copies load from pending when:
  - the counter wraps, or
  - the channel is disabled.
- Per-channel counter (CNT_W bits), enabled channel:
  - count == active_period → count ← 0, active ← pending, STATUS[n] ← 1.
  - otherwise count ← count+1.
  - Cycle length is period+1 clocks.
- pwm_out[n] is registered: 1 when enabled & (count < active_duty), else 0.
  - duty = 0 → constant 0.
  - duty > period → constant 1.
- period == 0 while enabled: counter stays 0, wrap fires every cycle, STATUS[n] set every cycle, output = (duty != 0).
- Disable (CTRL bit 0): counter ← 0, output ← 0 next edge, active ← pending, STATUS unchanged.
- Enable (0→1): counting starts from 0 with the freshly loaded active values. First pwm_out edge appears 1 cycle after the CTRL write completes.
- STATUS write: bits written 1 clear. If a wrap sets the same bit in the same cycle, set wins.
- IRQ registered: IRQ ← |(STATUS & INTEN). Asserts 1 cycle after the flag sets and deasserts 1 cycle after clear or mask.
- Reset (asynchronous, any time, including mid-period):
  - CTRL, STATUS, INTEN, counters ← 0.
  - pending/active PERIOD ← RST_PERIOD; pending/active DUTY ← RST_DUTY.
  - pwm_out ← 0, IRQ ← 0, PRDATA ← 0.
- Width rule: PWDATA[CNT_W-1:0] is stored; higher bits are ignored. Counter comparisons are unsigned, CNT_W bits.

Decomposition:
- Package apb_pwm_pkg: register offset constants (CTRL, STATUS, INTEN, CH_BASE = 0x10, CH_STRIDE = 8) and a function decoding channel index from offset.
- Sub-module pwm_channel (clock, reset, enable, load strobes, pending period/duty in; pwm, wrap pulse out) holds the counter, active registers and output flop.
- Top instantiates NUM_CH copies with a generate loop and owns the APB decode, CTRL/STATUS/INTEN and IRQ.

Test Plan:
- Reset values: after reset, read all registers → CTRL=0, STATUS=0, PERIOD/DUTY = reset values, pwm_out=0, IRQ=0. Read 0x7C (unmapped) → PSLVERR=1, PRDATA=0.
- Basic PWM: ch0 PERIOD=9, DUTY=3, CTRL=1 → pwm_out[0] high 3 clocks / low 7 clocks, repeating every 10 clocks. Other channels stay 0.
- Shadow update: mid-period, write DUTY=7 → current period keeps duty 3. From the next wrap, output is high 7 clocks, with no runt pulse.
- Boundaries: DUTY=0 → constant 0. DUTY=20 with PERIOD=9 → constant 1. PERIOD=0, DUTY=1 → constant 1 and STATUS[0] set every cycle.
- Interrupt: INTEN=1, ch0 PERIOD=4 → IRQ rises 1 cycle after the first wrap. W1C STATUS=1 issued in the same cycle as a wrap → bit remains 1. W1C in a non-wrap cycle → IRQ falls next cycle.
- Async reset mid-operation: assert PRESERN low between clock edges with 2 channels running → pwm_out and IRQ go 0 immediately. After release, channels stay idle until CTRL is rewritten.
